// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports (fetch and load/store) and the shared
// single-port memory command/response port into one interface.
//
// Signals:
//   if_req / if_addr / if_flush     fetch read request, address, redirect flush
//   if_gnt / if_rvalid / if_rdata   fetch grant and read response
//   ls_req / ls_we / ls_addr        LSU request, write flag, address
//   ls_wdata / ls_be                LSU write data and byte enables
//   ls_gnt / ls_rvalid / ls_rdata   LSU grant and read response
//   mem_en / mem_we / mem_addr      memory command valid, write, address
//   mem_wdata / mem_be              memory write data and byte enables
//   mem_rdata                       memory read data (fixed latency)
//
// Modports:
//   slave  - the arbiter's view
//   master - the requesters-plus-memory view (used by the environment)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [BE_W-1:0]   ls_be;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the fetch stage and the
// load/store unit. The LSU wins arbitration by default; a starvation counter
// hands the port to fetch after STARVE_MAX consecutive LSU grants made while
// fetch was waiting. One command is issued per cycle and read data is routed
// back to whichever requester issued the read, RD_LAT cycles later. A fetch
// flush discards every fetch read still in flight.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        mem_port_arbiter_if.slave (requester ports + memory port)
//
// Parameters:
//   ADDR_W, DATA_W  must match the interface instance
//   RD_LAT          memory read latency, 1..4
//   STARVE_MAX      LSU grants tolerated while fetch waits, 1..15
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int         BE_W       = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    logic [3:0]              starve_cnt;
    logic [3:0]              starve_next;
    logic                    if_gnt_c;
    logic                    ls_gnt_c;
    logic [RD_LAT-1:0]       pipe_valid;
    owner_e [RD_LAT-1:0]     pipe_owner;
    logic                    out_valid;
    owner_e                  out_owner;

    // Grant decision. Grants are forced low while reset is asserted so the
    // memory port stays quiet even if requesters keep their req high.
    // Fetch only beats a pending LSU request once the starvation limit is
    // reached, and never while it is being flushed.
    always_comb begin
        if_gnt_c = 1'b0;
        ls_gnt_c = 1'b0;
        if (i_reset_n) begin
            if_gnt_c = bus.if_req && !bus.if_flush &&
                       (!bus.ls_req || (starve_cnt == STARVE_LIM));
            ls_gnt_c = bus.ls_req && !if_gnt_c;
        end
    end

    // Starvation counter next value. It tracks LSU grants taken while fetch
    // was waiting and restarts whenever fetch is served or stops asking. It
    // saturates at the limit so a flush held at the limit cannot push it past
    // the point where fetch would win again.
    always_comb begin
        starve_next = starve_cnt;
        if (!bus.if_req || if_gnt_c) begin
            starve_next = 4'd0;
        end else if (ls_gnt_c && (starve_cnt != STARVE_LIM)) begin
            starve_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

    // Memory command mux. Fetch always reads full words; an idle port drives
    // zeros everywhere so nothing stale leaks onto the memory bus.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        if (if_gnt_c) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr;
            bus.mem_be   = {BE_W{1'b1}};
        end else if (ls_gnt_c) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.ls_we;
            bus.mem_addr  = bus.ls_addr;
            bus.mem_wdata = bus.ls_wdata;
            bus.mem_be    = bus.ls_be;
        end
    end

    // Response pipe: one {valid, owner} entry per cycle of read latency.
    // Stage 0 records this cycle's grant (writes enter as bubbles). Moving
    // down the pipe, a flush kills any fetch-owned entry so no response from
    // before the redirect ever reaches the fetch stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pipe_valid <= '0;
            pipe_owner <= {RD_LAT{OWNER_IF}};
        end else begin
            pipe_valid[0] <= if_gnt_c || (ls_gnt_c && !bus.ls_we);
            pipe_owner[0] <= ls_gnt_c ? OWNER_LS : OWNER_IF;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1] &&
                                 !(bus.if_flush && (pipe_owner[k-1] == OWNER_IF));
                pipe_owner[k] <= pipe_owner[k-1];
            end
        end
    end

    // Response routing from the last pipe stage. A fetch response arriving
    // in a flush cycle belongs to the old instruction stream, so it is
    // suppressed combinationally. Read data is zero unless its rvalid is up.
    always_comb begin
        out_valid     = pipe_valid[RD_LAT-1];
        out_owner     = pipe_owner[RD_LAT-1];
        bus.if_rvalid = out_valid && (out_owner == OWNER_IF) && !bus.if_flush;
        bus.ls_rvalid = out_valid && (out_owner == OWNER_LS);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;
        bus.if_gnt    = if_gnt_c;
        bus.ls_gnt    = ls_gnt_c;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with RD_LAT=2, STARVE_MAX=4.
// Provides a behavioural memory with a two-cycle read pipeline, drives
// directed and random traffic, and compares every output each cycle with a
// reference model built from the arbitration rules, a shadow memory and a
// queue of expected responses.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        int          due;
        bit          owner;   // 0 = fetch, 1 = LSU
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic reset_n;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: byte-masked writes, reads returned RD_LAT=2 cycles
    // after the command.
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    logic [31:0] rd_pipe0;
    logic [31:0] rd_pipe1;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
                end
            end else begin
                rd_pipe0 <= mem[bus.mem_addr[9:2]];
            end
        end
        rd_pipe1 <= rd_pipe0;
    end
    assign bus.mem_rdata = rd_pipe1;

    // Reference model state and stimulus copies.
    int    checks;
    int    failures;
    int    cycle;
    int    starve;
    resp_t exp_q[$];
    bit    cur_if_req, cur_flush, cur_ls_req, cur_ls_we;
    logic [31:0] cur_if_addr, cur_ls_addr, cur_ls_wdata;
    logic [3:0]  cur_ls_be;
    bit    last_exp_if, last_exp_ls;
    bit    last_obs_if_gnt;

    task automatic checkVal(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input bit if_req, input logic [31:0] if_addr, input bit flush,
                                 input bit ls_req, input bit ls_we, input logic [31:0] ls_addr,
                                 input logic [31:0] ls_wdata, input logic [3:0] ls_be);
        cur_if_req = if_req;   cur_if_addr = if_addr;   cur_flush = flush;
        cur_ls_req = ls_req;   cur_ls_we = ls_we;       cur_ls_addr = ls_addr;
        cur_ls_wdata = ls_wdata; cur_ls_be = ls_be;
        bus.if_req   = if_req;   bus.if_addr  = if_addr;  bus.if_flush = flush;
        bus.ls_req   = ls_req;   bus.ls_we    = ls_we;    bus.ls_addr  = ls_addr;
        bus.ls_wdata = ls_wdata; bus.ls_be    = ls_be;
    endtask

    // Evaluate the model for the current cycle, compare, then advance it.
    task automatic checkOutput();
        bit          exp_if, exp_ls, exp_if_rv, exp_ls_rv;
        logic [31:0] exp_data;
        logic [69:0] exp_mem;
        resp_t       r;

        exp_if = cur_if_req && !cur_flush && (!cur_ls_req || starve == STARVE_MAX);
        exp_ls = cur_ls_req && !exp_if;
        checkVal("if_gnt", 72'(bus.if_gnt), 72'(exp_if));
        checkVal("ls_gnt", 72'(bus.ls_gnt), 72'(exp_ls));

        exp_mem = '0;
        if (exp_if)      exp_mem = {1'b1, 1'b0, cur_if_addr, 32'h0, 4'hF};
        else if (exp_ls) exp_mem = {1'b1, cur_ls_we, cur_ls_addr, cur_ls_wdata, cur_ls_be};
        checkVal("mem_cmd", 72'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}),
                 72'(exp_mem));

        exp_if_rv = 1'b0; exp_ls_rv = 1'b0; exp_data = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            r = exp_q.pop_front();
            exp_data = r.data;
            if (r.owner) exp_ls_rv = 1'b1;
            else if (!cur_flush) exp_if_rv = 1'b1;
        end
        checkVal("if_rvalid", 72'(bus.if_rvalid), 72'(exp_if_rv));
        checkVal("ls_rvalid", 72'(bus.ls_rvalid), 72'(exp_ls_rv));
        checkVal("if_rdata", 72'(bus.if_rdata), 72'(exp_if_rv ? exp_data : 32'h0));
        checkVal("ls_rdata", 72'(bus.ls_rdata), 72'(exp_ls_rv ? exp_data : 32'h0));

        if (cur_flush) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (!exp_q[i].owner) exp_q.delete(i);
            end
        end
        if (exp_if) begin
            r.due = cycle + RD_LAT; r.owner = 1'b0; r.data = shadow[cur_if_addr[9:2]];
            exp_q.push_back(r);
        end else if (exp_ls && !cur_ls_we) begin
            r.due = cycle + RD_LAT; r.owner = 1'b1; r.data = shadow[cur_ls_addr[9:2]];
            exp_q.push_back(r);
        end else if (exp_ls) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_ls_be[b]) shadow[cur_ls_addr[9:2]][b*8 +: 8] = cur_ls_wdata[b*8 +: 8];
            end
        end

        if (!cur_if_req || exp_if) starve = 0;
        else if (exp_ls && starve < STARVE_MAX) starve++;

        last_exp_if     = exp_if;
        last_exp_ls     = exp_ls;
        last_obs_if_gnt = bus.if_gnt;
        cycle++;
    endtask

    task automatic cycleStep(input bit if_req, input logic [31:0] if_addr, input bit flush,
                             input bit ls_req, input bit ls_we, input logic [31:0] ls_addr,
                             input logic [31:0] ls_wdata, input logic [3:0] ls_be);
        applyStimulus(if_req, if_addr, flush, ls_req, ls_we, ls_addr, ls_wdata, ls_be);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycleStep(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_ctl"}, 72'({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid,
                                     bus.mem_en, bus.mem_we, bus.mem_be}), 72'(0));
        checkVal({tag, "_rdata"}, 72'({bus.if_rdata, bus.ls_rdata}), 72'(0));
        checkVal({tag, "_mem"}, 72'({bus.mem_addr, bus.mem_wdata}), 72'(0));
    endtask

    initial begin
        bit          if_pend, ls_pend, ls_we_r, flush_r;
        logic [31:0] if_a, ls_a, ls_d;
        logic [3:0]  ls_b;
        logic [9:0]  gnt_pattern;

        checks = 0; failures = 0; cycle = 0; starve = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = (i < 64) ? {8'hA5, 8'(i), 16'(i * 7 + 3)} : 32'h0;
            shadow[i] = mem[i];
        end
        rd_pipe0 = '0; rd_pipe1 = '0;

        // Reset state with requests high.
        reset_n = 1'b0;
        applyStimulus(1, 32'h10, 0, 1, 0, 32'h20, 32'h0, 4'hF);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch-only reads back to back.
        cycleStep(1, 32'h0, 0, 0, 0, 0, 0, 0);
        cycleStep(1, 32'h4, 0, 0, 0, 0, 0, 0);
        cycleStep(1, 32'h8, 0, 0, 0, 0, 0, 0);
        idle(3);

        // LSU partial write followed by read of the same word.
        cycleStep(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 4'b0011);
        cycleStep(0, 0, 0, 1, 0, 32'h100, 32'h0, 4'hF);
        cycleStep(0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("ls_rdata_beef", 72'(bus.ls_rdata), 72'(32'h0000BEEF));
        idle(2);

        // Both requesting continuously: LSU x4 then fetch, repeating.
        gnt_pattern = '0;
        if_a = 32'h40; ls_a = 32'h80;
        for (int i = 0; i < 10; i++) begin
            cycleStep(1, if_a, 0, 1, 0, ls_a, 0, 4'hF);
            gnt_pattern[i] = last_obs_if_gnt;
            if (last_exp_if) if_a = if_a + 4;
            if (last_exp_ls) ls_a = ls_a + 4;
        end
        checkVal("starve_pattern", 72'(gnt_pattern), 72'(10'b1000010000));
        idle(3);

        // Flush while two fetch reads are in flight and an LSU read is granted.
        cycleStep(1, 32'h0C, 0, 0, 0, 0, 0, 0);
        cycleStep(1, 32'h10, 0, 0, 0, 0, 0, 0);
        cycleStep(1, 32'h14, 1, 1, 0, 32'h18, 0, 4'hF);
        idle(4);

        // Reset pulsed mid-cycle with reads outstanding.
        cycleStep(1, 32'h1C, 0, 0, 0, 0, 0, 0);
        cycleStep(0, 0, 0, 1, 0, 32'h20, 0, 4'hF);
        applyStimulus(1, 32'h24, 0, 1, 0, 32'h28, 0, 4'hF);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("mid_reset");
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        exp_q.delete();
        starve = 0;
        @(posedge clk);
        #1;
        idle(3);

        // Random mixed traffic; each requester holds its request until granted.
        if_pend = 0; ls_pend = 0;
        if_a = 0; ls_a = 0; ls_d = 0; ls_b = 0; ls_we_r = 0;
        for (int i = 0; i < 400; i++) begin
            if (!if_pend && ($urandom_range(0, 2) != 0)) begin
                if_pend = 1;
                if_a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!ls_pend && ($urandom_range(0, 2) != 0)) begin
                ls_pend = 1;
                ls_we_r = $urandom_range(0, 1);
                ls_a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                ls_d = $urandom;
                ls_b = 4'($urandom_range(1, 15));
            end
            flush_r = ($urandom_range(0, 15) == 0);
            cycleStep(if_pend, if_a, flush_r, ls_pend, ls_we_r, ls_a, ls_d, ls_b);
            if (last_exp_if) if_pend = 0;
            if (last_exp_ls) ls_pend = 0;
        end
        idle(RD_LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
